// File: rtl/pht_branch_predictor.sv
// PC-indexed pattern history table of saturating counters, initialised by a walking-index FSM.
// Define PHT_GSHARE_EN to XOR a global history register into the table index.
module pht_branch_predictor #(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned HIST_W  = 6,
  parameter int unsigned PC_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [PC_W-1:0]   lookup_pc,
  output logic              pred_taken,
  output logic [HIST_W-1:0] pred_hist,
  input  logic              update_valid,
  input  logic [PC_W-1:0]   update_pc,
  input  logic              update_taken,
  input  logic [HIST_W-1:0] update_hist,
  input  logic              update_mispredict,
  output logic              init_busy,
  output logic [31:0]       mispredict_count
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] InitVal = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CtrMax  = {CTR_W{1'b1}};

  typedef enum logic {StInit, StRun} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] init_idx_q, init_idx_d;
  logic [31:0]      mcount_q, mcount_d;
  logic [CTR_W-1:0] pht_q [ENTRIES];

  logic [IDX_W-1:0] lookup_base, update_base, lookup_idx, update_idx;
  logic             do_update;
  logic             pht_we;
  logic [IDX_W-1:0] pht_waddr;
  logic [CTR_W-1:0] pht_wdata, upd_ctr;
  logic             unused_bits;

  assign lookup_base = lookup_pc[IDX_W+1:2];
  assign update_base = update_pc[IDX_W+1:2];
  assign do_update   = (state_q == StRun) && update_valid;

`ifdef PHT_GSHARE_EN
  logic [HIST_W-1:0] ghr_q, ghr_d;

  always_comb begin
    ghr_d = ghr_q;
    if (do_update) ghr_d = (ghr_q << 1) | HIST_W'(update_taken);
    if (flush)     ghr_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ghr_q <= '0;
    else      ghr_q <= ghr_d;
  end

  // Both sides see the pre-shift history, so a same-cycle update never skews the lookup.
  assign lookup_idx = lookup_base ^ IDX_W'(ghr_q);
  assign update_idx = update_base ^ IDX_W'(update_hist);
  assign pred_hist  = ghr_q;
`else
  assign lookup_idx = lookup_base;
  assign update_idx = update_base;
  assign pred_hist  = '0;
`endif

  assign unused_bits = ^{lookup_pc, update_pc, update_hist};

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    case (state_q)
      StInit: begin
        if (flush) begin
          init_idx_d = '0;
        end else begin
          init_idx_d = init_idx_q + IDX_W'(1);
          if (init_idx_q == IDX_W'(ENTRIES - 1)) state_d = StRun;
        end
      end
      StRun: begin
        if (flush) begin
          state_d    = StInit;
          init_idx_d = '0;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    mcount_d = mcount_q;
    if (do_update && update_mispredict && (mcount_q != 32'hFFFF_FFFF)) begin
      mcount_d = mcount_q + 32'd1;
    end
  end

  always_comb begin
    upd_ctr = pht_q[update_idx];
    if (update_taken) begin
      if (upd_ctr != CtrMax) upd_ctr = upd_ctr + CTR_W'(1);
    end else begin
      if (upd_ctr != '0) upd_ctr = upd_ctr - CTR_W'(1);
    end
  end

  always_comb begin
    pht_we    = 1'b0;
    pht_waddr = update_idx;
    pht_wdata = upd_ctr;
    if (state_q == StInit) begin
      pht_we    = 1'b1;
      pht_waddr = init_idx_q;
      pht_wdata = InitVal;
    end else if (do_update) begin
      pht_we = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StInit;
      init_idx_q <= '0;
      mcount_q   <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      mcount_q   <= mcount_d;
    end
  end

  // Table storage is not reset; the INIT walk defines every entry before use.
  always_ff @(posedge clk) begin
    if (pht_we) pht_q[pht_waddr] <= pht_wdata;
  end

  assign pred_taken       = (state_q == StRun) && pht_q[lookup_idx][CTR_W-1];
  assign init_busy        = (state_q == StInit);
  assign mispredict_count = mcount_q;

endmodule

// File: tb/tb_pht_branch_predictor.sv
// Directed and randomised checks of pht_branch_predictor against a table-of-integers reference model.
module tb_pht_branch_predictor;

  localparam int ENTRIES = 64;
  localparam int HIST_W  = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic [5:0]  pred_hist;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [5:0]  update_hist;
  logic        update_mispredict;
  logic        init_busy;
  logic [31:0] mispredict_count;

  int checks   = 0;
  int failures = 0;

  // Reference model: plain integers per entry, a cycles-remaining busy counter.
  int unsigned m_ctr [ENTRIES];
  int unsigned m_ghr;
  int          m_remaining;
  longint      m_count;

  always #5 clk = ~clk;

  pht_branch_predictor #(
    .ENTRIES(ENTRIES), .CTR_W(2), .HIST_W(HIST_W), .PC_W(32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .lookup_pc        (lookup_pc),
    .pred_taken       (pred_taken),
    .pred_hist        (pred_hist),
    .update_valid     (update_valid),
    .update_pc        (update_pc),
    .update_taken     (update_taken),
    .update_hist      (update_hist),
    .update_mispredict(update_mispredict),
    .init_busy        (init_busy),
    .mispredict_count (mispredict_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int midx(input logic [31:0] pc, input int unsigned hist);
`ifdef PHT_GSHARE_EN
    return int'((pc >> 2) % ENTRIES) ^ int'(hist);
`else
    return int'((pc >> 2) % ENTRIES);
`endif
  endfunction

  function automatic logic mpred(input logic [31:0] pc);
    if (m_remaining > 0) return 1'b0;
    return m_ctr[midx(pc, m_ghr)] >= 2;
  endfunction

  task automatic model_reinit();
    for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 1;
    m_ghr       = 0;
    m_remaining = ENTRIES;
  endtask

  // One clock: drive at negedge, check combinational outputs, advance model at posedge.
  task automatic step(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                      input logic ut, input logic um, input logic fl);
    int i;
    lookup_pc         = lpc;
    update_valid      = uv;
    update_pc         = upc;
    update_taken      = ut;
    update_mispredict = um;
    update_hist       = 6'(m_ghr);
    flush             = fl;
    #1;
    chk("pred_taken", {31'd0, pred_taken}, {31'd0, mpred(lpc)});
    chk("pred_hist", {26'd0, pred_hist}, 32'(m_ghr));
    chk("init_busy", {31'd0, init_busy}, {31'd0, m_remaining > 0});
    chk("mispredict_count", mispredict_count, 32'(m_count));
    @(posedge clk);
    if (fl) begin
      model_reinit();
    end else if (m_remaining > 0) begin
      m_remaining--;
    end else if (uv) begin
      i = midx(upc, m_ghr);
      if (ut) m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
      else    m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
`ifdef PHT_GSHARE_EN
      m_ghr = ((m_ghr << 1) | int'(ut)) % (1 << HIST_W);
`endif
      if (um && m_count < 64'hFFFF_FFFF) m_count++;
    end
    @(negedge clk);
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic exp);
    lookup_pc = pc;
    #1;
    chk(tag, {31'd0, pred_taken}, {31'd0, exp});
  endtask

  initial begin
    int n;
    rst = 1'b0; flush = 1'b0; lookup_pc = '0; update_valid = 1'b0; update_pc = '0;
    update_taken = 1'b0; update_hist = '0; update_mispredict = 1'b0;
    m_count = 0;
    model_reinit();
    @(negedge clk);
    @(negedge clk);
    chk("reset_busy", {31'd0, init_busy}, 32'd1);
    chk("reset_pred", {31'd0, pred_taken}, 32'd0);
    chk("reset_hist", {26'd0, pred_hist}, 32'd0);
    chk("reset_count", mispredict_count, 32'd0);

    rst = 1'b1;
    n = 0;
    while (init_busy === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("init_cycles", 32'(n), 32'd64);
    m_remaining = 0;
    look("post_init_0x100", 32'h100, 1'b0);
    look("post_init_0x37c", 32'h37C, 1'b0);

    step(32'h100, 1, 32'h100, 1, 1, 0);
    step(32'h100, 1, 32'h100, 1, 1, 0);
`ifndef PHT_GSHARE_EN
    look("train_taken", 32'h100, 1'b1);
`endif
    step(32'h100, 1, 32'h100, 0, 0, 0);
    step(32'h100, 1, 32'h100, 0, 0, 0);
`ifndef PHT_GSHARE_EN
    look("train_back", 32'h100, 1'b0);
`endif
    for (int k = 0; k < 5; k++) step(32'h310, 1, 32'h310, 1, 0, 0);
    step(32'h310, 1, 32'h310, 0, 0, 0);
`ifndef PHT_GSHARE_EN
    look("saturate_hold", 32'h310, 1'b1);
`endif
    step(32'h200, 1, 32'h200, 1, 0, 0);
`ifndef PHT_GSHARE_EN
    look("alias_0x100", 32'h100, 1'b1);
    look("alias_0x104", 32'h104, 1'b0);
    look("same_cycle_pre", 32'h40, 1'b0);
`endif
    step(32'h40, 1, 32'h40, 1, 0, 0);
`ifndef PHT_GSHARE_EN
    look("same_cycle_post", 32'h40, 1'b1);
`endif
    chk("count_directed", mispredict_count, 32'd2);

    step(32'h100, 0, 32'h0, 0, 0, 1);
    for (int k = 0; k < ENTRIES; k++) begin
      step($urandom_range(0, 255) << 2, 1, $urandom_range(0, 255) << 2, 1'($urandom), 1, 0);
    end
    chk("flush_busy_done", {31'd0, init_busy}, 32'd0);
    chk("flush_count_kept", mispredict_count, 32'd2);
    look("flush_0x100", 32'h100, 1'b0);
    look("flush_0x310", 32'h310, 1'b0);

    for (int k = 0; k < 20; k++) step(32'h0, 1, 32'h100, 1, 1, 0);
    step(32'h0, 0, 32'h0, 0, 0, 1);
    for (int k = 0; k < ENTRIES; k++) step(32'h0, 1, 32'h100, 1, 1, 0);
    chk("init_restart_done", {31'd0, init_busy}, 32'd0);

`ifdef PHT_GSHARE_EN
    step(32'h100, 1, 32'h500, 1, 0, 0);
    step(32'h100, 1, 32'h500, 1, 0, 0);
    step(32'h100, 1, 32'h500, 0, 0, 0);
    lookup_pc = 32'h100;
    #1;
    chk("gshare_hist", {26'd0, pred_hist}, 32'h6);
    step(32'h100, 0, 32'h0, 0, 0, 0);
`endif

    for (int k = 0; k < 400; k++) begin
      logic uv;
      logic fl;
      uv = 1'($urandom);
      fl = ($urandom_range(0, 149) == 0) && !uv;
      step($urandom_range(0, 255) << 2, uv, $urandom_range(0, 63) << 2, 1'($urandom),
           1'($urandom), fl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
